elevator_call_scheduler: RTL

Collective-selective call scheduler for the 8-floor elevator car. It latches cabin buttons (`btn_in`) and hall buttons (`btn_up_out`, `btn_down_out`) into pending-request registers. From the car's current level and the service direction, it selects the next target floor. It clears requests as floors are served. It sits between the button inputs and the `elevator` motion/door controller, which consumes `target`/`target_valid` and reports `level`, `moving` and `serve`.

---
 rtl/elevator_call_scheduler_pkg.sv | 19 +
 rtl/elevator_call_scheduler_floor_pick.sv | 40 ++++
 rtl/elevator_call_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/elevator_call_scheduler_pkg.sv
// Shared encodings for the elevator call scheduler: service states,
// direction values and the floor-pick search modes.
package elevator_call_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] PICK_LOW_ABOVE  = 2'd0;
  localparam logic [1:0] PICK_HIGH_ABOVE = 2'd1;
  localparam logic [1:0] PICK_HIGH_BELOW = 2'd2;
  localparam logic [1:0] PICK_LOW_BELOW  = 2'd3;

endpackage

// File: rtl/elevator_call_scheduler_floor_pick.sv
// Finds the lowest or highest requested floor strictly above or strictly
// below the car's current level.
module elevator_floor_pick
  import elevator_call_scheduler_pkg::*;
#(
  parameter int FLOORS  = 8,
  parameter int LEVEL_W = 3
) (
  input  logic [FLOORS-1:0]  req,
  input  logic [LEVEL_W-1:0] level,
  input  logic [1:0]         mode,
  output logic               found,
  output logic [LEVEL_W-1:0] floor
);

  logic want_low;
  logic want_above;

  assign want_low   = (mode == PICK_LOW_ABOVE) || (mode == PICK_LOW_BELOW);
  assign want_above = (mode == PICK_LOW_ABOVE) || (mode == PICK_HIGH_ABOVE);

  // The last hit in scan order wins, so "lowest" scans from the top down.
  always_comb begin
    int  f;
    logic cand;
    found = 1'b0;
    floor = '0;
    f     = 0;
    cand  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      f    = want_low ? (FLOORS - 1 - i) : i;
      cand = req[f] && (want_above ? (LEVEL_W'(f) > level) : (LEVEL_W'(f) < level));
      if (cand) begin
        found = 1'b1;
        floor = LEVEL_W'(f);
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective-selective call scheduler: latches cabin and hall calls, picks the
// next stop from the car level and service direction, clears served calls.
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int FLOORS  = 8,
  parameter int LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-2:0]  btn_up_out,
  input  logic [FLOORS-1:1]  btn_down_out,
  input  logic [LEVEL_W-1:0] level,
  input  logic               moving,
  input  logic               serve,
  output logic [LEVEL_W-1:0] target,
  output logic               target_valid,
  output logic               direction,
  output logic [1:0]         state,
  output logic [FLOORS-1:0]  pend_in,
  output logic [FLOORS-2:0]  pend_up,
  output logic [FLOORS-1:1]  pend_down
);

  logic [FLOORS-1:0]  pend_in_p0;
  logic [FLOORS-2:0]  pend_up_p0;
  logic [FLOORS-1:1]  pend_down_p0;

  logic [FLOORS-1:0]  up_full, down_full, any_req, here_sel;
  logic [FLOORS-1:0]  req_up_dir, req_down_dir;
  logic [FLOORS-1:0]  clr_in, clr_up, clr_down;
  logic               any_above, any_below, any_here;
  logic [LEVEL_W-1:0] near_above, near_below, dist_up, dist_dn;

  logic               la_found, ha_found, hb_found, lb_found;
  logic [LEVEL_W-1:0] la_floor, ha_floor, hb_floor, lb_floor;

  state_t             st_p1, st_nx;
  logic               dir_p1, dir_nx;
  logic [LEVEL_W-1:0] target_p1, tgt_nx;
  logic               vld_p1, vld_nx;

  // Hall vectors widened to one bit per floor; the missing end calls read as 0.
  assign up_full      = {1'b0, pend_up_p0};
  assign down_full    = {pend_down_p0, 1'b0};
  assign any_req      = pend_in_p0 | up_full | down_full;
  assign req_up_dir   = pend_in_p0 | up_full;
  assign req_down_dir = pend_in_p0 | down_full;

  always_comb begin
    any_above  = 1'b0;
    any_below  = 1'b0;
    any_here   = 1'b0;
    near_above = '0;
    near_below = '0;
    here_sel   = '0;
    for (int f = FLOORS - 1; f >= 0; f--) begin
      if (any_req[f] && (LEVEL_W'(f) > level)) begin
        any_above  = 1'b1;
        near_above = LEVEL_W'(f);
      end
    end
    for (int f = 0; f < FLOORS; f++) begin
      if (any_req[f] && (LEVEL_W'(f) < level)) begin
        any_below  = 1'b1;
        near_below = LEVEL_W'(f);
      end
      if (LEVEL_W'(f) == level) begin
        here_sel[f] = 1'b1;
        if (any_req[f]) any_here = 1'b1;
      end
    end
  end

  assign dist_up = near_above - level;
  assign dist_dn = level - near_below;

  // A hall call against the travel direction stays lit unless this is the last
  // stop in that direction.
  always_comb begin
    clr_in   = '0;
    clr_up   = '0;
    clr_down = '0;
    if (serve) begin
      case (st_p1)
        ST_UP: begin
          clr_in   = here_sel;
          clr_up   = here_sel;
          clr_down = any_above ? '0 : here_sel;
        end
        ST_DOWN: begin
          clr_in   = here_sel;
          clr_down = here_sel;
          clr_up   = any_below ? '0 : here_sel;
        end
        default: begin
          clr_in   = here_sel;
          clr_up   = here_sel;
          clr_down = here_sel;
        end
      endcase
    end
  end

  // Stage 0: pending request lamps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_in_p0   <= '0;
      pend_up_p0   <= '0;
      pend_down_p0 <= '0;
    end else begin
      pend_in_p0   <= (pend_in_p0 | btn_in) & ~clr_in;
      pend_up_p0   <= (pend_up_p0 | btn_up_out) & ~clr_up[FLOORS-2:0];
      pend_down_p0 <= (pend_down_p0 | btn_down_out) & ~clr_down[FLOORS-1:1];
    end
  end

  elevator_floor_pick #(.FLOORS(FLOORS), .LEVEL_W(LEVEL_W)) u_pick_la (
    .req(req_up_dir), .level(level), .mode(PICK_LOW_ABOVE),
    .found(la_found), .floor(la_floor)
  );

  elevator_floor_pick #(.FLOORS(FLOORS), .LEVEL_W(LEVEL_W)) u_pick_ha (
    .req(down_full), .level(level), .mode(PICK_HIGH_ABOVE),
    .found(ha_found), .floor(ha_floor)
  );

  elevator_floor_pick #(.FLOORS(FLOORS), .LEVEL_W(LEVEL_W)) u_pick_hb (
    .req(req_down_dir), .level(level), .mode(PICK_HIGH_BELOW),
    .found(hb_found), .floor(hb_floor)
  );

  elevator_floor_pick #(.FLOORS(FLOORS), .LEVEL_W(LEVEL_W)) u_pick_lb (
    .req(up_full), .level(level), .mode(PICK_LOW_BELOW),
    .found(lb_found), .floor(lb_floor)
  );

  // Direction may only change while the car is stopped; ties from IDLE go up.
  always_comb begin
    st_nx = st_p1;
    if (!moving) begin
      case (st_p1)
        ST_IDLE: begin
          if (any_above && (!any_below || (dist_up <= dist_dn))) st_nx = ST_UP;
          else if (any_below)                                     st_nx = ST_DOWN;
        end
        ST_UP:   if (!any_above) st_nx = any_below ? ST_DOWN : ST_IDLE;
        ST_DOWN: if (!any_below) st_nx = any_above ? ST_UP : ST_IDLE;
        default: st_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tgt_nx = target_p1;
    vld_nx = 1'b0;
    dir_nx = dir_p1;
    case (st_nx)
      ST_UP: begin
        dir_nx = DIR_UP;
        if (la_found) begin
          tgt_nx = la_floor;
          vld_nx = 1'b1;
        end else if (ha_found) begin
          tgt_nx = ha_floor;
          vld_nx = 1'b1;
        end
      end
      ST_DOWN: begin
        dir_nx = DIR_DOWN;
        if (hb_found) begin
          tgt_nx = hb_floor;
          vld_nx = 1'b1;
        end else if (lb_found) begin
          tgt_nx = lb_floor;
          vld_nx = 1'b1;
        end
      end
      default: begin
        if (any_here) begin
          tgt_nx = level;
          vld_nx = 1'b1;
        end
      end
    endcase
  end

  // Stage 1: service state, direction and target.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_p1     <= ST_IDLE;
      dir_p1    <= DIR_UP;
      target_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      st_p1     <= st_nx;
      dir_p1    <= dir_nx;
      target_p1 <= tgt_nx;
      vld_p1    <= vld_nx;
    end
  end

  assign target       = target_p1;
  assign target_valid = vld_p1;
  assign direction    = dir_p1;
  assign state        = st_p1;
  assign pend_in      = pend_in_p0;
  assign pend_up      = pend_up_p0;
  assign pend_down    = pend_down_p0;

endmodule
